// File: rtl/clk_div_pkg.sv
// Shared constants and divisor helpers for the programmable clock divider.
// Helpers work on 32-bit values; callers cast to their own WIDTH (WIDTH <= 32).
package clk_div_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned MIN_DIV   = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] value);
        return (value < 32'(MIN_DIV)) ? 32'(MIN_DIV) : value;
    endfunction

    function automatic logic [31:0] half_div(input logic [31:0] div);
        return div >> 1;
    endfunction

    function automatic logic [31:0] quarter_div(input logic [31:0] div);
        return div >> 2;
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Shadow divisor register with pending flag, clamp-on-capture and load bypass.
// next_div_c is the divisor a period boundary would adopt this cycle.
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_in_i,
    input  logic             div_ld_i,
    input  logic             apply_i,
    output logic [WIDTH-1:0] next_div_c,
    output logic             take_c,
    output logic             pend_o
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] div_clamped_c;

    assign div_clamped_c = WIDTH'(clamp_div(32'(div_in_i)));

    // A load in the same cycle as a boundary bypasses the shadow register.
    assign next_div_c = div_ld_i ? div_clamped_c : shadow_q;
    assign take_c     = pend_q | div_ld_i;
    assign pend_o     = pend_q;

    always_comb begin
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (div_ld_i) begin
            shadow_d = div_clamped_c;
            pend_d   = 1'b1;
        end
        if (apply_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= WIDTH'(DEFAULT_DIV);
            pend_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable synchronous clock divider: registered q, one-cycle tick, glitch-free divisor update.
// Define CLK_DIV_QUAD_EN to add q_quad, a copy of q delayed by a quarter period.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_ld,
    input  logic             sync,
`ifdef CLK_DIV_QUAD_EN
    output logic             q_quad,
`endif
    output logic             q,
    output logic             tick,
    output logic             pend
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic             q_q, q_d;
    logic             tick_q, tick_d;
    logic             wrap_c;
    logic             last_c;
    logic             take_c;
    logic [WIDTH-1:0] next_div_c;
    logic [WIDTH-1:0] half_c;

    clk_div_shadow #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .div_in_i   (div_in),
        .div_ld_i   (div_ld),
        .apply_i    (wrap_c),
        .next_div_c (next_div_c),
        .take_c     (take_c),
        .pend_o     (pend)
    );

    assign last_c = (cnt_q == (cur_div_q - WIDTH'(1)));
    assign wrap_c = en & (sync | last_c);
    assign half_c = WIDTH'(half_div(32'(cur_div_d)));

    // Counter, divisor adoption at period start, and next-state outputs.
    always_comb begin
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        q_d       = q_q;
        tick_d    = 1'b0;
        if (en) begin
            cnt_d  = wrap_c ? '0 : (cnt_q + WIDTH'(1));
            tick_d = wrap_c;
            if (wrap_c && take_c) begin
                cur_div_d = next_div_c;
            end
        end
        if (en) begin
            q_d = (cnt_d < half_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= WIDTH'(DEFAULT_DIV - 1);
            cur_div_q <= WIDTH'(DEFAULT_DIV);
            q_q       <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            q_q       <= q_d;
            tick_q    <= tick_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;

`ifdef CLK_DIV_QUAD_EN
    logic             q_quad_q, q_quad_d;
    logic [WIDTH-1:0] quarter_c;

    assign quarter_c = WIDTH'(quarter_div(32'(cur_div_d)));

    // Quarter + half is below the divisor, so the sum cannot overflow WIDTH.
    always_comb begin
        q_quad_d = q_quad_q;
        if (en) begin
            q_quad_d = (cnt_d >= quarter_c) && (cnt_d < (quarter_c + half_c));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_quad_q <= 1'b0;
        end else begin
            q_quad_q <= q_quad_d;
        end
    end

    assign q_quad = q_quad_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: period-level reference model feeds an expectation queue.
module tb_clk_div_prog;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned DEFAULT_DIV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             div_ld = 1'b0;
    logic             sync = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             q, tick, pend;
`ifdef CLK_DIV_QUAD_EN
    logic             q_quad;
`endif

    clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .div_in (div_in),
        .div_ld (div_ld),
        .sync   (sync),
`ifdef CLK_DIV_QUAD_EN
        .q_quad (q_quad),
`endif
        .q      (q),
        .tick   (tick),
        .pend   (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit q;
        bit tick;
        bit pend;
        bit quad;
        int pos;
        int d;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: position within the current period and the divisor in force.
    int m_pos;
    int m_d;
    int m_shadow;
    bit m_pend;

    function automatic void check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pos    = int'(DEFAULT_DIV) - 1;
        m_d      = int'(DEFAULT_DIV);
        m_shadow = int'(DEFAULT_DIV);
        m_pend   = 1'b0;
    endfunction

    function automatic void model_step(input bit r, input bit e, input bit l,
                                       input int din, input bit s);
        exp_t x;
        bit   tk      = 1'b0;
        bit   applied = 1'b0;
        int   cl      = (din < 2) ? 2 : din;
        if (!r) begin
            model_reset();
            x = '{q: 1'b0, tick: 1'b0, pend: 1'b0, quad: 1'b0, pos: m_pos, d: m_d};
            exp_q.push_back(x);
            return;
        end
        if (e) begin
            if (s || (m_pos + 1 == m_d)) begin
                m_pos = 0;
                tk    = 1'b1;
                if (m_pend || l) begin
                    m_d     = l ? cl : m_shadow;
                    applied = 1'b1;
                end
            end else begin
                m_pos++;
            end
        end
        if (l) m_shadow = cl;
        if (applied) m_pend = 1'b0;
        else if (l) m_pend = 1'b1;
        x.q    = (m_pos < m_d / 2);
        x.tick = tk;
        x.pend = m_pend;
        x.quad = (m_pos >= m_d / 4) && (m_pos < m_d / 4 + m_d / 2);
        x.pos  = m_pos;
        x.d    = m_d;
        exp_q.push_back(x);
    endfunction

    task automatic cyc(input bit r, input bit e, input bit l, input int din, input bit s);
        @(negedge clk);
        rst    = r;
        en     = e;
        div_ld = l;
        div_in = WIDTH'(din);
        sync   = s;
        model_step(r, e, l, din, s);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
    endtask

    // Advance until the model sits at period position tgt with divisor d (bounded).
    task automatic run_until(input int tgt, input int d);
        for (int i = 0; i < 64; i++) begin
            if (m_pos == tgt && m_d == d) break;
            cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        end
        check("reach_pos", m_pos, tgt);
        check("reach_div", m_d, d);
    endtask

    // Monitor: one expectation per checked edge, compared just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check($sformatf("q[pos%0d/D%0d]", x.pos, x.d), int'(q), int'(x.q));
                check($sformatf("tick[pos%0d/D%0d]", x.pos, x.d), int'(tick), int'(x.tick));
                check($sformatf("pend[pos%0d/D%0d]", x.pos, x.d), int'(pend), int'(x.pend));
`ifdef CLK_DIV_QUAD_EN
                check($sformatf("q_quad[pos%0d/D%0d]", x.pos, x.d), int'(q_quad), int'(x.quad));
`endif
            end
        end
    end

    initial begin
        model_reset();
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // Default divide-by-4 out of reset.
        run(12);

        // Load 5 mid-period; the current 4-period must finish intact.
        run_until(1, 4);
        cyc(1'b1, 1'b1, 1'b1, 5, 1'b0);
        run(15);

        // Divisors 0 and 1 clamp to 2.
        cyc(1'b1, 1'b1, 1'b1, 0, 1'b0);
        run(8);
        cyc(1'b1, 1'b1, 1'b1, 9, 1'b0);
        run(3);
        cyc(1'b1, 1'b1, 1'b1, 1, 1'b0);
        run(12);

        // Freeze with en low at position 2 of D=6.
        cyc(1'b1, 1'b1, 1'b1, 6, 1'b0);
        run_until(2, 6);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 7, 1'b0);
        run(16);

        // sync with simultaneous load of 3 at position 3 of D=8.
        cyc(1'b1, 1'b1, 1'b1, 8, 1'b0);
        run_until(3, 8);
        cyc(1'b1, 1'b1, 1'b1, 3, 1'b1);
        run(9);

        // Asynchronous reset mid-period with a pending divisor.
        cyc(1'b1, 1'b1, 1'b1, 7, 1'b0);
        run(1);
        @(posedge clk);
        #3;
        check("pend_before_rst", int'(pend), 1);
        rst = 1'b0;
        #1;
        check("async_rst_q", int'(q), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_pend", int'(pend), 0);
        model_reset();
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        run(10);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit r = ($urandom_range(199) != 0);
            bit e = ($urandom_range(99) < 80);
            bit l = ($urandom_range(99) < 10);
            int d = int'($urandom_range(12));
            bit s = ($urandom_range(99) < 5);
            cyc(r, e, l, d, s);
        end

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Parametrised, fully synchronous programmable clock divider. It replaces the fixed ripple divide-by-2/4 chains.
- Produces a registered divided clock `q` and a one-cycle `tick` clock-enable from a single `clk`.
- Divisor is runtime-loadable and is applied glitch-free only at period boundaries.
- Sits in the SAM timing path, feeding video/CPU phase generation and downstream clock-enabled logic.

Parameters:
- WIDTH, 8, width of divisor and internal counter.
- DEFAULT_DIV, 4, divisor loaded at reset; must be >= 2 and < 2^WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; low freezes all state.
- div_in  input  WIDTH  requested divisor D.
- div_ld  input  1  one-cycle load strobe; captures div_in into shadow.
- sync  input  1  phase restart strobe.
- q  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse at start of each q period.
- pend  output  1  shadow divisor awaiting application.

Behaviour:
- Reset (rst low, async):
  - cur_div = DEFAULT_DIV, shadow = DEFAULT_DIV, cnt = DEFAULT_DIV-1.
  - q = 0, tick = 0, pend = 0.
- Clamp rule: any loaded divisor value < 2 is clamped to 2. Clamping happens on capture.
- Counter, each enabled edge:
  - cnt_n = 0 if (cnt == cur_div-1 or sync), else cnt+1.
  - Wrap = cnt_n == 0.
- Outputs are registered from next state:
  - q <= (cnt_n < floor(D/2)), where D is the divisor in force for the new period.
  - tick <= (cnt_n == 0).
  - Result: q is high for floor(D/2) cycles and low for ceil(D/2) cycles.
  - q rises in the same cycle tick is high.
- First enabled edge after reset gives cnt = 0, q = 1, tick = 1. Latency from rst release with en = 1 is one edge.
- en low:
  - cnt, q, cur_div and pend hold; tick is forced 0.
  - div_ld is still accepted; the shadow updates and pend sets.
- div_ld (regardless of en):
  - shadow <= clamp(div_in), pend <= 1.
  - A repeated load while pend is set overwrites shadow; last write wins.
- Application:
  - On an enabled wrap edge with pend set (or div_ld in the same cycle), cur_div <= shadow (or the bypassed div_in) and pend <= 0.
  - The new D governs q/half of the period starting at cnt 0.
  - No partial or short periods are emitted except on sync.
- sync (enabled edge):
  - Forces cnt_n = 0 and q = 1, tick = 1.
  - Applies any pending or simultaneous divisor immediately.
  - sync with en low is ignored.
- Divisor equal to the current one with div_ld: pend still sets and clears at the next wrap; no phase change.
- Reset mid-operation: immediate return to the reset values above; the shadow is lost.

Optional Feature:
- Macro: CLK_DIV_QUAD_EN.
- Defined:
  - Adds output `q_quad` (1 bit), reset 0.
  - `q_quad` is high while floor(D/4) <= cnt_n < floor(D/4)+floor(D/2).
  - Effectively q delayed by floor(D/4) cycles with the same high width, for two-phase E/Q style clocks.
- Undefined: port and logic absent; other behaviour identical.

Decomposition:
- Package clk_div_pkg holds:
  - default WIDTH constant;
  - MIN_DIV = 2 constant;
  - a clamp function (returns max(value, MIN_DIV) at WIDTH);
  - half/quarter derivation functions shared with the quad option.
- One sub-module, clk_div_shadow:
  - holds the shadow register, pend flag, clamp, and bypass mux;
  - exports the effective next divisor and an apply strobe input.
- Counter and output registers stay in the top level.

Test Plan:
- Reset release, en = 1, default D = 4 -> q sequence 1,1,0,0 repeating; tick high every 4th cycle aligned with q rise; pend = 0.
- div_ld with div_in = 5 at cnt = 1 -> pend = 1 until the next wrap; then q pattern 1,1,0,0,0 (2 high, 3 low); tick every 5 cycles; first 4-period completes intact.
- div_ld with div_in = 0, then separately 1 -> both clamp to D = 2; q toggles every cycle 1,0,1,0; tick on every q-high cycle.
- en low for 3 cycles at cnt = 2 of D = 6 -> q and cnt frozen, tick = 0; resume continues at cnt = 3 with no extra or short period.
- sync at cnt = 3 of D = 8, with div_ld div_in = 3 in the same cycle -> next cycle cnt = 0, q = 1, tick = 1, D = 3 in force, pend = 0.
- rst asserted mid-period with pend = 1 -> q = 0, tick = 0, pend = 0 asynchronously; after release the D = 4 default pattern resumes. With CLK_DIV_QUAD_EN at D = 8, q_quad is high for cnt 2..5.
